// File: rtl/frog_game_ctrl_if.sv
// Signal bundle between the frog game controller and its frame source / consumers.
// The master side drives per-pixel masks and frame pulses; the slave side returns game state.
interface frog_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               i_pix_stb;
  logic               i_animate;
  logic               i_start;
  logic               i_fr;
  logic [2:0]         i_hazard;
  logic [11:0]        i_frog_y1;
  logic [1:0]         o_state;
  logic [2:0]         o_lives;
  logic [SCORE_W-1:0] o_score;
  logic               o_freeze;
  logic               o_flash;
  logic               o_frog_rst;

  modport master (
    output i_pix_stb, i_animate, i_start, i_fr, i_hazard, i_frog_y1,
    input  o_state, o_lives, o_score, o_freeze, o_flash, o_frog_rst
  );

  modport slave (
    input  i_pix_stb, i_animate, i_start, i_fr, i_hazard, i_frog_y1,
    output o_state, o_lives, o_score, o_freeze, o_flash, o_frog_rst
  );
endinterface

// File: rtl/frog_game_ctrl.sv
// Frog game state machine: per-frame hit/goal evaluation, lives, score and respawn control.
// Optional macro FROG_BONUS_LIFE_EN grants a life on every 4th goal (capped at LIVES).
module frog_game_ctrl #(
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60,
  parameter int WIN_FRAMES = 30,
  parameter int GOAL_Y     = 40,
  parameter int SCORE_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  frog_game_ctrl_if.slave  bus
);

  localparam logic [2:0]  LIVES_L = 3'(LIVES);
  localparam logic [7:0]  HIT_L   = 8'(HIT_FRAMES);
  localparam logic [7:0]  WIN_L   = 8'(WIN_FRAMES);
  localparam logic [11:0] GOAL_L  = 12'(GOAL_Y);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    HIT  = 2'b01,
    WIN  = 2'b10,
    OVER = 2'b11
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         lives, lives_nxt;
  logic [SCORE_W-1:0] score, score_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               hit_flag, hit_nxt;
  logic               flash, flash_nxt;
  logic               frog_rst, frog_rst_nxt;
  logic               freeze;
  logic               overlap;
  logic               frame_hit;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    overlap      = bus.i_pix_stb & bus.i_fr & (|bus.i_hazard) & (state == PLAY);
    frame_hit    = hit_flag | overlap;
    state_nxt    = state;
    lives_nxt    = lives;
    score_nxt    = score;
    cnt_nxt      = cnt;
    flash_nxt    = flash;
    frog_rst_nxt = 1'b0;

    case (state)
      PLAY: begin
        if (bus.i_animate) begin
          if (frame_hit) begin
            if (lives == 3'd1) begin
              lives_nxt = 3'd0;
              state_nxt = OVER;
            end else begin
              lives_nxt = lives - 3'd1;
              cnt_nxt   = HIT_L;
              state_nxt = HIT;
            end
          end else if (bus.i_frog_y1 <= GOAL_L) begin
            score_nxt = sat_inc(score);
            cnt_nxt   = WIN_L;
            state_nxt = WIN;
`ifdef FROG_BONUS_LIFE_EN
            if ((score_nxt[1:0] == 2'b00) && (lives < LIVES_L))
              lives_nxt = lives + 3'd1;
`endif
          end
        end
      end
      HIT: begin
        if (bus.i_animate) begin
          cnt_nxt   = cnt - 8'd1;
          flash_nxt = ~flash;
          if (cnt == 8'd1) begin
            flash_nxt    = 1'b0;
            frog_rst_nxt = 1'b1;
            state_nxt    = PLAY;
          end
        end
      end
      WIN: begin
        if (bus.i_animate) begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) begin
            frog_rst_nxt = 1'b1;
            state_nxt    = PLAY;
          end
        end
      end
      default: begin
        // Restart is level-sampled on any cycle, not tied to the frame pulse
        if (bus.i_start) begin
          lives_nxt    = LIVES_L;
          score_nxt    = '0;
          frog_rst_nxt = 1'b1;
          state_nxt    = PLAY;
        end
      end
    endcase

    hit_nxt = (bus.i_animate || (state_nxt != state)) ? 1'b0 : frame_hit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= PLAY;
      lives    <= LIVES_L;
      score    <= '0;
      cnt      <= '0;
      hit_flag <= 1'b0;
      flash    <= 1'b0;
      frog_rst <= 1'b0;
      freeze   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lives    <= lives_nxt;
      score    <= score_nxt;
      cnt      <= cnt_nxt;
      hit_flag <= hit_nxt;
      flash    <= flash_nxt;
      frog_rst <= frog_rst_nxt;
      freeze   <= (state_nxt != PLAY);
    end
  end

  assign bus.o_state    = state;
  assign bus.o_lives    = lives;
  assign bus.o_score    = score;
  assign bus.o_freeze   = freeze;
  assign bus.o_flash    = flash;
  assign bus.o_frog_rst = frog_rst;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Bench for frog_game_ctrl: directed scenarios followed by randomized frames against a frame-level model.
module tb_frog_game_ctrl;
  localparam int LIVES      = 3;
  localparam int HIT_FRAMES = 60;
  localparam int WIN_FRAMES = 30;
  localparam int GOAL_Y     = 40;
  localparam int SCORE_W    = 8;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
  localparam int S_PLAY = 0, S_HIT = 1, S_WIN = 2, S_OVER = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frog_game_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  frog_game_ctrl #(
    .LIVES(LIVES), .HIT_FRAMES(HIT_FRAMES), .WIN_FRAMES(WIN_FRAMES),
    .GOAL_Y(GOAL_Y), .SCORE_W(SCORE_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int m_state, m_lives, m_score, m_cnt;
  bit m_flash;
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_pix_stb = 1'b0;
    bus.i_animate = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_fr      = 1'b0;
    bus.i_hazard  = 3'b000;
  endtask

  task automatic check_all(input string tag, input bit exp_rst);
    check({tag, "_state"},  32'(bus.o_state),    32'(m_state));
    check({tag, "_lives"},  32'(bus.o_lives),    32'(m_lives));
    check({tag, "_score"},  32'(bus.o_score),    32'(m_score));
    check({tag, "_freeze"}, 32'(bus.o_freeze),   32'(m_state != S_PLAY));
    check({tag, "_flash"},  32'(bus.o_flash),    32'(m_flash));
    check({tag, "_frgrst"}, 32'(bus.o_frog_rst), 32'(exp_rst));
  endtask

  // One frame's worth of game rules, applied at the frame pulse
  task automatic model_frame(input bit h, input int y, output bit exp_rst);
    exp_rst = 1'b0;
    case (m_state)
      S_PLAY: begin
        if (h) begin
          if (m_lives == 1) begin
            m_lives = 0;
            m_state = S_OVER;
          end else begin
            m_lives = m_lives - 1;
            m_cnt   = HIT_FRAMES;
            m_state = S_HIT;
          end
        end else if (y <= GOAL_Y) begin
          m_score = (m_score == SCORE_MAX) ? SCORE_MAX : m_score + 1;
          m_cnt   = WIN_FRAMES;
          m_state = S_WIN;
`ifdef FROG_BONUS_LIFE_EN
          if ((m_score % 4 == 0) && (m_lives < LIVES)) m_lives = m_lives + 1;
`endif
        end
      end
      S_HIT: begin
        m_cnt   = m_cnt - 1;
        m_flash = !m_flash;
        if (m_cnt == 0) begin
          m_flash = 1'b0;
          m_state = S_PLAY;
          exp_rst = 1'b1;
        end
      end
      S_WIN: begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_state = S_PLAY;
          exp_rst = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_state = S_PLAY;
    m_lives = LIVES;
    m_score = 0;
    m_cnt   = 0;
    m_flash = 1'b0;
  endtask

  task automatic do_frame(input int npix, input bit want_hit, input int y, input bit rand_start);
    logic       stb, fr;
    logic [2:0] haz;
    bit         h, exp_rst;
    h = 1'b0;
    bus.i_frog_y1 = 12'(y);
    for (int i = 0; i <= npix; i++) begin
      stb = 1'($urandom);
      fr  = 1'($urandom);
      haz = 3'($urandom);
      if (!want_hit && stb && fr && (haz != 3'b000)) fr = 1'b0;
      if (want_hit && (i == npix / 2)) begin
        stb = 1'b1;
        fr  = 1'b1;
        haz = 3'b010;
      end
      bus.i_pix_stb = stb;
      bus.i_fr      = fr;
      bus.i_hazard  = haz;
      bus.i_animate = (i == npix);
      bus.i_start   = rand_start ? 1'($urandom) : 1'b0;
      if ((m_state == S_PLAY) && stb && fr && (haz != 3'b000)) h = 1'b1;
      tick();
      if (i < npix) check("quiet_frgrst", 32'(bus.o_frog_rst), 32'd0);
    end
    clear_inputs();
    model_frame(h, y, exp_rst);
    check_all("frame", exp_rst);
  endtask

  task automatic do_restart();
    bit exp_rst;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    exp_rst = 1'b0;
    if (m_state == S_OVER) begin
      model_reset();
      exp_rst = 1'b1;
    end
    check_all("restart", exp_rst);
    tick();
    check("restart_pulse_end", 32'(bus.o_frog_rst), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_all("reset", 1'b0);
    tick();
    check("reset_no_frgrst", 32'(bus.o_frog_rst), 32'd0);
  endtask

  task automatic run_frames(input int n, input bit want_hit, input int y, input bit rand_start);
    for (int k = 0; k < n; k++) do_frame($urandom_range(2, 6), want_hit, y, rand_start);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.i_frog_y1 = 12'd200;
    tick();
    tick();
    do_reset();

    // Idle play, far from the goal
    run_frames(3, 1'b0, 200, 1'b0);

    // First hit, full countdown with flashing; i_start is ignored throughout
    do_frame(5, 1'b1, 200, 1'b0);
    run_frames(HIT_FRAMES, 1'b0, 200, 1'b1);

    // Goal exactly at the boundary, then just below it
    do_frame(4, 1'b0, GOAL_Y, 1'b0);
    run_frames(WIN_FRAMES, 1'b0, 200, 1'b0);
    do_frame(4, 1'b0, GOAL_Y + 1, 1'b0);

    // Hit and goal in the same frame: hit wins
    do_frame(4, 1'b1, 10, 1'b0);
    run_frames(HIT_FRAMES, 1'b0, 200, 1'b1);

    // Last life lost, overlap during OVER ignored, then restart
    do_frame(4, 1'b1, 200, 1'b0);
    run_frames(2, 1'b1, 200, 1'b0);
    do_restart();

    // Reset in the middle of a HIT countdown
    do_frame(4, 1'b1, 200, 1'b0);
    run_frames(41, 1'b0, 200, 1'b0);
    do_reset();

    // One hit then four goals: bonus-life behaviour on the 4th goal
    do_frame(3, 1'b1, 200, 1'b0);
    run_frames(HIT_FRAMES, 1'b0, 200, 1'b0);
    for (int g = 0; g < 4; g++) begin
      do_frame(3, 1'b0, 5, 1'b0);
      run_frames(WIN_FRAMES, 1'b0, 200, 1'b0);
    end

    // Randomized frames
    for (int r = 0; r < 300; r++) begin
      if (m_state == S_OVER && $urandom_range(0, 1) == 1) begin
        do_restart();
      end else if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        do_frame($urandom_range(0, 6), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, GOAL_Y) : $urandom_range(GOAL_Y + 1, 4095),
                 (m_state != S_OVER));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
